traffic_demand_controller: RTL and testbench
============================================

Name: traffic_demand_controller

Overview:
- Parametrised successor to the single-road country-car controller.
- Tracks waiting-car demand on N_CH side roads during the main-road green phase. Raises a per-channel one-cycle COUNTRY_PULSE when a channel's accumulated demand exceeds THRESH.
- Keeps per-hour traffic totals in an external memory using a handshaked read-modify-write FSM with a one-entry coalescing pending buffer.
- Sits between the sensor front-end and the light sequencer / traffic-history memory.

Parameters:
- N_CH, 2: number of side-road channels.
- CAR_W, 3: width of each car-count sample.
- ACC_W, 7: per-channel demand accumulator width.
- THRESH, 30: demand threshold; the pulse fires when the new sum is greater than THRESH. Must be < 2^ACC_W - 1.
- HOUR_W, 5: hour index width, which is also the memory address width.
- TRAF_W, 10: stored per-hour traffic total width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- MAIN_GREEN  in  1  main-road green phase; demand is counted only while this is 1.
- CAR_VALID  in  N_CH  per-channel sample strobe.
- CAR_NUM  in  N_CH*CAR_W  per-channel car count; channel i occupies bits [i*CAR_W +: CAR_W].
- COUNTRY_PULSE  out  N_CH  one-cycle demand pulse per channel.
- TRAF_VALID  in  1  traffic sample strobe.
- TRAF_AMOUNT  in  CAR_W  traffic sample value.
- HOUR  in  HOUR_W  hour tag of the sample.
- MEM_REQ  out  1  memory request, one cycle per access.
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ=1.
- MEM_ADDR  out  HOUR_W  access address.
- MEM_WDATA  out  TRAF_W  write data.
- MEM_RDATA  in  TRAF_W  read data; valid while MEM_RVALID=1.
- MEM_RVALID  in  1  read-data-valid; arrives 1 or more cycles after the read request.
- BUSY  out  1  FSM not in IDLE, or pending buffer full.
- DROP  out  1  one-cycle pulse when a sample is discarded.

Behaviour:
- Reset (asynchronous):
  - All accumulators, pending buffer and FSM clear; FSM goes to IDLE.
  - Outputs reset to: COUNTRY_PULSE=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, DROP=0, BUSY=0.
  - A MEM_RVALID for a read issued before reset is ignored (MEM_RVALID is ignored outside RD_WAIT).
- Demand channel i (channels are independent; simultaneous pulses are legal):
  - When MAIN_GREEN=0: ACC[i] <= 0 every cycle; COUNTRY_PULSE[i] <= 0.
  - When MAIN_GREEN=1 and CAR_VALID[i]=1: sum = ACC[i] + CAR_NUM[i], computed at ACC_W+1 bits.
    - If sum > THRESH: COUNTRY_PULSE[i] <= 1 (registered, asserted the cycle after the strobe) and ACC[i] <= 0.
    - Otherwise: ACC[i] <= sum, saturated at 2^ACC_W - 1; COUNTRY_PULSE[i] <= 0.
  - In every other cycle COUNTRY_PULSE[i] <= 0, so the pulse is exactly one cycle wide.
  - A CAR_VALID with CAR_NUM=0 is a no-op.
- Hourly FSM states: IDLE, RD_REQ, RD_WAIT, WR.
  - IDLE: on TRAF_VALID, latch (HOUR, TRAF_AMOUNT) into the active register and go to RD_REQ. Otherwise, if pending is full, move pending to active, clear pending, and go to RD_REQ.
  - RD_REQ (1 cycle): MEM_REQ=1, MEM_WE=0, MEM_ADDR=active hour. Go to RD_WAIT.
  - RD_WAIT: hold until MEM_RVALID=1. Capture wsum = MEM_RDATA + active amount, saturated at 2^TRAF_W - 1. Go to WR.
  - WR (1 cycle): MEM_REQ=1, MEM_WE=1, MEM_ADDR=active hour, MEM_WDATA=wsum.
    - If pending is full (before this cycle's TRAF_VALID is applied), move pending to active and go to RD_REQ; otherwise go to IDLE.
  - Read-after-write ordering is guaranteed because the next read is issued after the write cycle. The memory must return the most recently written data.
  - Minimum latency: TRAF_VALID at cycle 0 gives the read at cycle 1, and the write one cycle after MEM_RVALID.
- Pending buffer rules for TRAF_VALID while the FSM is not in IDLE:
  - Pending empty, or freed this cycle by the WR→RD_REQ transfer: store the sample.
  - Pending full with the same hour: pending amount += TRAF_AMOUNT, saturated at 2^TRAF_W - 1.
  - Pending full with a different hour: discard the sample; DROP <= 1 for one cycle.
- MEM_REQ is never asserted for two consecutive cycles in the same state. MEM_WDATA and MEM_ADDR hold their last values while idle.

Test Plan:
1. THRESH=30, MAIN_GREEN=1, ch0 CAR_NUM=7 strobed 5 times → ACC 7, 14, 21, 28; pulse on ch0 one cycle after the 5th strobe (sum 35); ACC0=0; ch1 stays 0.
2. ACC0=28, MAIN_GREEN drops to 0 → ACC0=0 next cycle; strobes during red produce no pulse. Both channels crossing THRESH on the same cycle → both pulse bits high together.
3. TRAF_VALID, HOUR=3, AMOUNT=5; memory returns 100 after 2 cycles → read addr 3, then write addr 3 data 105; FSM returns to IDLE; BUSY low afterwards.
4. During sample 3's RD_WAIT: send HOUR=4 AMOUNT=2, then HOUR=4 AMOUNT=6, then HOUR=7 AMOUNT=1 → pending HOUR=4 amount 8; HOUR=7 dropped with a single DROP pulse; second RMW is addr 4 with +8.
5. Stored value 1020, amount 7 → MEM_WDATA=1023 (saturated).
6. Assert RST during RD_WAIT, then a late MEM_RVALID → no write issued; all outputs 0; pending cleared.

Source files
------------

// File: rtl/traffic_demand_controller_if.sv
// Traffic-history memory port.
// The controller (master) issues one-cycle read or write requests and the
// memory (slave) answers reads with a one-cycle MEM_RVALID strobe some cycles
// later.
//   MEM_REQ     master->slave  request strobe, one cycle per access
//   MEM_WE      master->slave  1 = write, 0 = read (valid with MEM_REQ)
//   MEM_ADDR    master->slave  hour index
//   MEM_WDATA   master->slave  per-hour total to store
//   MEM_RDATA   slave->master  stored total (valid with MEM_RVALID)
//   MEM_RVALID  slave->master  read data valid
interface traffic_demand_controller_if #(
    parameter int HOUR_W = 5,
    parameter int TRAF_W = 10
);
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [HOUR_W-1:0] MEM_ADDR;
    logic [TRAF_W-1:0] MEM_WDATA;
    logic [TRAF_W-1:0] MEM_RDATA;
    logic              MEM_RVALID;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA, MEM_RVALID
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA, MEM_RVALID
    );
endinterface

// File: rtl/traffic_demand_controller.sv
// Side-road demand tracker and hourly traffic-total updater.
//
// Demand: each of N_CH side roads accumulates car counts while the main road
// is green; when the running sum passes THRESH the channel raises a one-cycle
// COUNTRY_PULSE and restarts from zero. Leaving green clears all demand.
//
// History: traffic samples are added to a per-hour total held in an external
// memory via read-modify-write (IDLE -> RD_REQ -> RD_WAIT -> WR). One extra
// sample can wait in a pending buffer; further samples for the same hour merge
// into it, samples for another hour are dropped.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   MAIN_GREEN      main-road green phase (demand counted only when 1)
//   CAR_VALID       per-channel sample strobe
//   CAR_NUM         per-channel count, channel i at [i*CAR_W +: CAR_W]
//   COUNTRY_PULSE   per-channel one-cycle demand pulse
//   TRAF_VALID      traffic sample strobe
//   TRAF_AMOUNT     traffic sample value
//   HOUR            hour tag of the traffic sample
//   mem             traffic-history memory port (master side)
//   BUSY            update in progress or a sample is pending
//   DROP            one-cycle pulse when a traffic sample is discarded
module traffic_demand_controller #(
    parameter int N_CH   = 2,
    parameter int CAR_W  = 3,
    parameter int ACC_W  = 7,
    parameter int THRESH = 30,
    parameter int HOUR_W = 5,
    parameter int TRAF_W = 10
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MAIN_GREEN,
    input  logic [N_CH-1:0]          CAR_VALID,
    input  logic [N_CH*CAR_W-1:0]    CAR_NUM,
    output logic [N_CH-1:0]          COUNTRY_PULSE,
    input  logic                     TRAF_VALID,
    input  logic [CAR_W-1:0]         TRAF_AMOUNT,
    input  logic [HOUR_W-1:0]        HOUR,
    traffic_demand_controller_if.master mem,
    output logic                     BUSY,
    output logic                     DROP
);

    // ------------------------------------------------------------------
    // Demand channels
    // ------------------------------------------------------------------
    localparam logic [ACC_W:0] THRESH_EXT = (ACC_W+1)'(THRESH);
    localparam logic [ACC_W:0] ACC_MAX    = {1'b0, {ACC_W{1'b1}}};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic             pulse;
        logic [ACC_W:0]   sum;

        // One extra bit so the threshold compare sees the true sum.
        assign sum = {1'b0, acc} + (ACC_W+1)'(CAR_NUM[i*CAR_W +: CAR_W]);
        assign COUNTRY_PULSE[i] = pulse;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                acc   <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (!MAIN_GREEN) begin
                    acc <= '0;
                end else if (CAR_VALID[i]) begin
                    if (sum > THRESH_EXT) begin
                        pulse <= 1'b1;
                        acc   <= '0;
                    end else if (sum > ACC_MAX) begin
                        acc <= '1;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hourly read-modify-write FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR} state_t;

    state_t            state, state_nx;
    logic [HOUR_W-1:0] act_hour;
    logic [TRAF_W-1:0] act_amt;
    logic              pend_full;
    logic [HOUR_W-1:0] pend_hour;
    logic [TRAF_W-1:0] pend_amt;
    logic [TRAF_W-1:0] wdata_q;
    logic              drop_q;

    logic [TRAF_W:0]   wsum_full;
    logic [TRAF_W-1:0] wsum;
    logic [TRAF_W:0]   merge_full;
    logic [TRAF_W-1:0] merge_sum;
    logic [TRAF_W-1:0] amt_ext;
    logic              load_new;
    logic              load_pend;
    logic              pend_freed;
    logic              pend_store;
    logic              pend_merge;

    assign amt_ext    = TRAF_W'(TRAF_AMOUNT);
    assign wsum_full  = {1'b0, mem.MEM_RDATA} + {1'b0, act_amt};
    assign wsum       = wsum_full[TRAF_W] ? '1 : wsum_full[TRAF_W-1:0];
    assign merge_full = {1'b0, pend_amt} + {1'b0, amt_ext};
    assign merge_sum  = merge_full[TRAF_W] ? '1 : merge_full[TRAF_W-1:0];

    // The WR cycle hands the pending entry to the active register, so a
    // sample arriving in that same cycle may take the freed slot.
    assign pend_freed = (state == WR) && pend_full;
    assign load_new   = (state == IDLE) && TRAF_VALID;
    assign load_pend  = ((state == IDLE) && !TRAF_VALID && pend_full) || pend_freed;
    assign pend_store = !pend_full || pend_freed;
    assign pend_merge = pend_full && !pend_freed && (HOUR == pend_hour);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        mem.MEM_REQ = 1'b0;
        mem.MEM_WE  = 1'b0;
        case (state)
            IDLE: begin
                if (TRAF_VALID || pend_full) state_nx = RD_REQ;
            end
            RD_REQ: begin
                mem.MEM_REQ = 1'b1;
                state_nx    = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem.MEM_RVALID) state_nx = WR;
            end
            WR: begin
                mem.MEM_REQ = 1'b1;
                mem.MEM_WE  = 1'b1;
                state_nx    = pend_full ? RD_REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            act_hour  <= '0;
            act_amt   <= '0;
            pend_full <= 1'b0;
            pend_hour <= '0;
            pend_amt  <= '0;
            wdata_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= 1'b0;

            if (load_new) begin
                act_hour <= HOUR;
                act_amt  <= amt_ext;
            end else if (load_pend) begin
                act_hour <= pend_hour;
                act_amt  <= pend_amt;
            end

            if (load_pend) pend_full <= 1'b0;

            // Later assignment wins: a refill overrides the clear above.
            if (TRAF_VALID && (state != IDLE)) begin
                if (pend_store) begin
                    pend_full <= 1'b1;
                    pend_hour <= HOUR;
                    pend_amt  <= amt_ext;
                end else if (pend_merge) begin
                    pend_amt <= merge_sum;
                end else begin
                    drop_q <= 1'b1;
                end
            end

            if ((state == RD_WAIT) && mem.MEM_RVALID) wdata_q <= wsum;
        end
    end

    // Address and data are registers, so they hold their last values while idle.
    assign mem.MEM_ADDR  = act_hour;
    assign mem.MEM_WDATA = wdata_q;
    assign BUSY          = (state != IDLE) || pend_full;
    assign DROP          = drop_q;

endmodule

// File: tb/tb_traffic_demand_controller.sv
module tb_traffic_demand_controller;
    localparam int N_CH   = 2;
    localparam int CAR_W  = 3;
    localparam int HOUR_W = 5;
    localparam int TRAF_W = 10;

    typedef struct {
        logic              we;
        logic [HOUR_W-1:0] addr;
        logic [TRAF_W-1:0] data;
    } op_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  main_green;
    logic [N_CH-1:0]       car_valid;
    logic [N_CH*CAR_W-1:0] car_num;
    logic [N_CH-1:0]       country_pulse;
    logic                  traf_valid;
    logic [CAR_W-1:0]      traf_amount;
    logic [HOUR_W-1:0]     hour;
    logic                  busy;
    logic                  drop;

    logic                  resp_rvalid;
    logic                  man_rvalid;
    logic [TRAF_W-1:0]     resp_rdata;
    logic [TRAF_W-1:0]     man_rdata;

    traffic_demand_controller_if #(.HOUR_W(HOUR_W), .TRAF_W(TRAF_W)) mif();

    assign mif.MEM_RVALID = resp_rvalid | man_rvalid;
    assign mif.MEM_RDATA  = man_rvalid ? man_rdata : resp_rdata;

    traffic_demand_controller #(
        .N_CH(N_CH), .CAR_W(CAR_W), .ACC_W(7), .THRESH(30),
        .HOUR_W(HOUR_W), .TRAF_W(TRAF_W)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .MAIN_GREEN   (main_green),
        .CAR_VALID    (car_valid),
        .CAR_NUM      (car_num),
        .COUNTRY_PULSE(country_pulse),
        .TRAF_VALID   (traf_valid),
        .TRAF_AMOUNT  (traf_amount),
        .HOUR         (hour),
        .mem          (mif),
        .BUSY         (busy),
        .DROP         (drop)
    );

    always #5 clk = ~clk;

    op_t               exp_q[$];
    logic [TRAF_W-1:0] mem_model [2**HOUR_W];
    int                tests_run    = 0;
    int                tests_failed = 0;
    int                rd_lat       = 2;
    bit                auto_resp    = 1'b1;
    int                resp_cnt     = 0;
    logic [HOUR_W-1:0] resp_addr;

    function automatic op_t mk(input logic we, input int a, input int d);
        op_t o;
        o.we   = we;
        o.addr = a[HOUR_W-1:0];
        o.data = d[TRAF_W-1:0];
        return o;
    endfunction

    // Memory model + scoreboard: every request is compared against the
    // oldest expected access; reads are answered rd_lat cycles later.
    initial begin
        op_t e;
        resp_rvalid = 1'b0;
        resp_rdata  = '0;
        resp_addr   = '0;
        forever begin
            @(negedge clk);
            resp_rvalid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    resp_rvalid = 1'b1;
                    resp_rdata  = mem_model[resp_addr];
                end
            end
            if (mif.MEM_REQ === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL mem_unexpected: got we=%0b addr=%0d wdata=%0d, required no request",
                             mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA);
                end else begin
                    e = exp_q.pop_front();
                    if (mif.MEM_WE !== e.we || mif.MEM_ADDR !== e.addr ||
                        (e.we && mif.MEM_WDATA !== e.data)) begin
                        tests_failed++;
                        $display("FAIL mem_access: got we=%0b addr=%0d wdata=%0d, required we=%0b addr=%0d wdata=%0d",
                                 mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, e.we, e.addr, e.data);
                    end
                end
                if (mif.MEM_WE === 1'b1) begin
                    mem_model[mif.MEM_ADDR] = mif.MEM_WDATA;
                end else if (auto_resp) begin
                    resp_cnt  = rd_lat;
                    resp_addr = mif.MEM_ADDR;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] v, input logic [2:0] n1, input logic [2:0] n0);
        car_valid = v;
        car_num   = {n1, n0};
        tick();
        car_valid = '0;
        car_num   = '0;
    endtask

    task automatic send(input int h, input int a);
        traf_valid  = 1'b1;
        hour        = h[HOUR_W-1:0];
        traf_amount = a[CAR_W-1:0];
        tick();
        traf_valid  = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d outstanding accesses busy=%0b, required 0 and busy=0",
                     name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({country_pulse, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, drop, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pulse=%0b req=%0b we=%0b addr=%0d wdata=%0d drop=%0b busy=%0b, required all 0",
                     country_pulse, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, drop, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_demand_threshold();
        logic [1:0] exp;
        main_green = 1'b1;
        for (int k = 0; k < 5; k++) begin
            strobe(2'b01, 3'd0, 3'd7);
            exp = (k == 4) ? 2'b01 : 2'b00;
            tests_run++;
            if (country_pulse !== exp) begin
                tests_failed++;
                $display("FAIL threshold_strobe%0d: got pulse=%b, required %b", k, country_pulse, exp);
            end
            tick();
        end
        tests_run++;
        if (country_pulse !== 2'b00) begin
            tests_failed++;
            $display("FAIL pulse_width: got pulse=%b, required 00", country_pulse);
        end
    endtask

    task automatic test_green_clear_and_both();
        // ch0 to 28 while green.
        for (int k = 0; k < 4; k++) strobe(2'b01, 3'd0, 3'd7);
        // Red: accumulators clear and strobes are ignored.
        main_green = 1'b0;
        for (int k = 0; k < 2; k++) begin
            strobe(2'b11, 3'd7, 3'd7);
            tests_run++;
            if (country_pulse !== 2'b00) begin
                tests_failed++;
                $display("FAIL red_strobe%0d: got pulse=%b, required 00", k, country_pulse);
            end
        end
        main_green = 1'b1;
        // Both channels 7,14,21,28 from a cleared start: no pulse.
        for (int k = 0; k < 4; k++) begin
            strobe(2'b11, 3'd7, 3'd7);
            tests_run++;
            if (country_pulse !== 2'b00) begin
                tests_failed++;
                $display("FAIL after_red_strobe%0d: got pulse=%b, required 00", k, country_pulse);
            end
        end
        // ch0 reaches exactly 30, ch1 strobed with 0: neither fires.
        strobe(2'b11, 3'd0, 3'd2);
        tests_run++;
        if (country_pulse !== 2'b00) begin
            tests_failed++;
            $display("FAIL at_threshold: got pulse=%b, required 00", country_pulse);
        end
        // ch0 31, ch1 31: both fire together.
        strobe(2'b11, 3'd3, 3'd1);
        tests_run++;
        if (country_pulse !== 2'b11) begin
            tests_failed++;
            $display("FAIL both_pulse: got pulse=%b, required 11", country_pulse);
        end
        tick();
    endtask

    task automatic test_rmw_basic();
        mem_model[3] = 10'd100;
        rd_lat = 2;
        exp_q.push_back(mk(1'b0, 3, 0));
        exp_q.push_back(mk(1'b1, 3, 105));
        send(3, 5);
        tests_run++;
        if (mif.MEM_REQ !== 1'b1 || mif.MEM_WE !== 1'b0 || mif.MEM_ADDR !== 5'd3) begin
            tests_failed++;
            $display("FAIL read_latency: got req=%0b we=%0b addr=%0d, required req=1 we=0 addr=3",
                     mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR);
        end
        wait_drain(40, "rmw_basic");
    endtask

    task automatic test_pending_coalesce();
        rd_lat = 6;
        exp_q.push_back(mk(1'b0, 3, 0));
        exp_q.push_back(mk(1'b1, 3, 110));
        exp_q.push_back(mk(1'b0, 4, 0));
        exp_q.push_back(mk(1'b1, 4, 8));
        send(3, 5);
        tick();
        send(4, 2);
        tests_run++;
        if (drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_store_drop: got drop=%0b, required 0", drop);
        end
        send(4, 6);
        tests_run++;
        if (drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_merge_drop: got drop=%0b, required 0", drop);
        end
        send(7, 1);
        tests_run++;
        if (drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_pulse: got drop=%0b, required 1", drop);
        end
        tick();
        tests_run++;
        if (drop !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_width: got drop=%0b busy=%0b, required drop=0 busy=1", drop, busy);
        end
        wait_drain(60, "pending");
    endtask

    task automatic test_saturation();
        mem_model[9] = 10'd1020;
        rd_lat = 1;
        exp_q.push_back(mk(1'b0, 9, 0));
        exp_q.push_back(mk(1'b1, 9, 1023));
        send(9, 7);
        wait_drain(40, "saturation");
    endtask

    task automatic test_back_to_back();
        rd_lat = 1;
        mem_model[1] = '0;
        mem_model[2] = '0;
        mem_model[5] = '0;
        exp_q.push_back(mk(1'b0, 1, 0));
        exp_q.push_back(mk(1'b1, 1, 1));
        exp_q.push_back(mk(1'b0, 2, 0));
        exp_q.push_back(mk(1'b1, 2, 5));
        exp_q.push_back(mk(1'b0, 5, 0));
        exp_q.push_back(mk(1'b1, 5, 4));
        send(1, 1);
        send(2, 2);
        send(2, 3);
        // Lands in the WR cycle, taking the slot freed by the hand-over.
        send(5, 4);
        tests_run++;
        if (drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL freed_slot_drop: got drop=%0b, required 0", drop);
        end
        wait_drain(60, "back_to_back");
    endtask

    task automatic test_reset_mid_read();
        auto_resp = 1'b0;
        exp_q.push_back(mk(1'b0, 5, 0));
        send(5, 1);
        tick();
        send(6, 2);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_in_wait: got busy=%0b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({country_pulse, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, drop, busy} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got pulse=%0b req=%0b we=%0b addr=%0d wdata=%0d drop=%0b busy=%0b, required all 0",
                     country_pulse, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, drop, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        man_rdata  = 10'd50;
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests_run++;
            if (mif.MEM_REQ !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL late_rvalid%0d: got req=%0b busy=%0b, required req=0 busy=0",
                         k, mif.MEM_REQ, busy);
            end
        end
        auto_resp = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        main_green  = 1'b0;
        car_valid   = '0;
        car_num     = '0;
        traf_valid  = 1'b0;
        traf_amount = '0;
        hour        = '0;
        man_rvalid  = 1'b0;
        man_rdata   = '0;
        for (int i = 0; i < 2**HOUR_W; i++) mem_model[i] = '0;

        test_reset();
        test_demand_threshold();
        test_green_clear_and_both();
        test_rmw_basic();
        test_pending_coalesce();
        test_saturation();
        test_back_to_back();
        test_reset_mid_read();

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: got %0d outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
